// File: rtl/leds_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, CTRL fields,
// pattern modes and arbiter states.
package leds_pattern_sequencer_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_PATTERN = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_CPU_PRI  = 3;

    localparam int STATUS_DIR   = 16;
    localparam int STATUS_PHASE = 17;
    localparam int STATUS_PEND  = 18;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WR   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/leds_pattern_gen.sv
// Tick prescaler and next-pattern logic (rotate / bounce / blink) for the LED sequencer.
module leds_pattern_gen
    import leds_pattern_sequencer_pkg::*;
#(
    parameter int          LED_WIDTH      = 10,
    parameter int          PRESCALE_WIDTH = 24,
    parameter int unsigned PATTERN_RESET  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic [PRESCALE_WIDTH-1:0] period,
    input  logic                      load,
    input  logic [LED_WIDTH-1:0]      load_value,
    output logic                      tick,
    output logic [LED_WIDTH-1:0]      cur,
    output logic                      dir,
    output logic                      phase,
    output logic [LED_WIDTH-1:0]      display
);

    logic [PRESCALE_WIDTH-1:0] presc;
    logic [PRESCALE_WIDTH-1:0] period_eff;
    logic                      armed;
    logic                      active;
    logic [LED_WIDTH-1:0]      cur_nxt;
    logic                      dir_nxt;
    logic                      phase_nxt;

    assign active     = en && (mode != MODE_MANUAL);
    assign period_eff = (period == '0) ? PRESCALE_WIDTH'(1) : period;
    assign display    = phase ? '0 : cur;

    // The first active cycle after enable preloads so the first tick lands PERIOD cycles later.
    always_comb begin
        tick = 1'b0;
        if (active) tick = armed ? (presc == '0) : (period_eff == PRESCALE_WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !active) begin
            presc <= '0;
            armed <= 1'b0;
        end else if (!armed) begin
            armed <= 1'b1;
            presc <= (period_eff == PRESCALE_WIDTH'(1)) ? '0 : period_eff - PRESCALE_WIDTH'(2);
        end else if (presc == '0) begin
            presc <= period_eff - PRESCALE_WIDTH'(1);
        end else begin
            presc <= presc - PRESCALE_WIDTH'(1);
        end
    end

    always_comb begin
        cur_nxt   = cur;
        dir_nxt   = dir;
        phase_nxt = phase;
        case (mode)
            MODE_ROTATE: cur_nxt = {cur[LED_WIDTH-2:0], cur[LED_WIDTH-1]};
            MODE_BOUNCE: begin
                // Reflect at the edge: an end bit about to fall off flips direction instead.
                if (dir == DIR_LEFT) begin
                    if (cur[LED_WIDTH-1]) begin
                        dir_nxt = DIR_RIGHT;
                        cur_nxt = {1'b0, cur[LED_WIDTH-1:1]};
                    end else begin
                        cur_nxt = {cur[LED_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (cur[0]) begin
                        dir_nxt = DIR_LEFT;
                        cur_nxt = {cur[LED_WIDTH-2:0], 1'b0};
                    end else begin
                        cur_nxt = {1'b0, cur[LED_WIDTH-1:1]};
                    end
                end
            end
            MODE_BLINK: phase_nxt = ~phase;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur   <= LED_WIDTH'(PATTERN_RESET);
            dir   <= DIR_LEFT;
            phase <= 1'b0;
        end else if (load) begin
            cur   <= load_value;
            dir   <= DIR_LEFT;
            phase <= 1'b0;
        end else if (tick) begin
            cur   <= cur_nxt;
            dir   <= dir_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/leds_pattern_sequencer.sv
// LED PIO controller: config register file, pattern generator and a two-way
// arbiter (CPU channel vs sequencer) driving the PIO's single-cycle write port.
module leds_pattern_sequencer
    import leds_pattern_sequencer_pkg::*;
#(
    parameter int          LED_WIDTH      = 10,
    parameter int          PRESCALE_WIDTH = 24,
    parameter int unsigned PERIOD_RESET   = 50000,
    parameter int unsigned PATTERN_RESET  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           s_address,
    input  logic                 s_chipselect,
    input  logic                 s_write_n,
    input  logic [31:0]          s_writedata,
    output logic [31:0]          s_readdata,
    input  logic                 cpu_req,
    input  logic [LED_WIDTH-1:0] cpu_data,
    output logic                 cpu_ack,
    output logic [1:0]           pio_address,
    output logic                 pio_chipselect,
    output logic                 pio_write_n,
    output logic [31:0]          pio_writedata,
    output logic                 busy
);

    logic                      ctrl_en;
    logic [1:0]                ctrl_mode;
    logic                      ctrl_cpu_pri;
    logic [PRESCALE_WIDTH-1:0] period;
    logic [LED_WIDTH-1:0]      pattern;
    logic                      seq_pend;
    arb_state_t                state;

    logic                      cfg_wr;
    logic                      pattern_load;
    logic                      tick;
    logic [LED_WIDTH-1:0]      cur;
    logic                      dir;
    logic                      phase;
    logic [LED_WIDTH-1:0]      display;
    logic                      grant_cpu;
    logic                      grant_seq;
    logic                      wdata_unused;

    assign cfg_wr       = s_chipselect && !s_write_n;
    assign pattern_load = cfg_wr && (s_address == ADDR_PATTERN);
    assign wdata_unused = &{1'b0, s_writedata};
    assign pio_address  = 2'b00;
    assign busy         = (state == ST_WR) || seq_pend || cpu_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_en      <= 1'b0;
            ctrl_mode    <= MODE_MANUAL;
            ctrl_cpu_pri <= 1'b0;
            period       <= PRESCALE_WIDTH'(PERIOD_RESET);
            pattern      <= LED_WIDTH'(PATTERN_RESET);
        end else if (cfg_wr) begin
            case (s_address)
                ADDR_CTRL: begin
                    ctrl_en      <= s_writedata[CTRL_EN];
                    ctrl_mode    <= s_writedata[CTRL_MODE_LSB +: 2];
                    ctrl_cpu_pri <= s_writedata[CTRL_CPU_PRI];
                end
                ADDR_PERIOD:  period  <= s_writedata[PRESCALE_WIDTH-1:0];
                ADDR_PATTERN: pattern <= s_writedata[LED_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            ADDR_CTRL: begin
                s_readdata[CTRL_EN]              = ctrl_en;
                s_readdata[CTRL_MODE_LSB +: 2]   = ctrl_mode;
                s_readdata[CTRL_CPU_PRI]         = ctrl_cpu_pri;
            end
            ADDR_PERIOD:  s_readdata[PRESCALE_WIDTH-1:0] = period;
            ADDR_PATTERN: s_readdata[LED_WIDTH-1:0]      = pattern;
            default: begin
                s_readdata[LED_WIDTH-1:0] = cur;
                s_readdata[STATUS_DIR]    = dir;
                s_readdata[STATUS_PHASE]  = phase;
                s_readdata[STATUS_PEND]   = seq_pend;
            end
        endcase
    end

    leds_pattern_gen #(
        .LED_WIDTH      (LED_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .PATTERN_RESET  (PATTERN_RESET)
    ) u_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (ctrl_en),
        .mode       (ctrl_mode),
        .period     (period),
        .load       (pattern_load),
        .load_value (s_writedata[LED_WIDTH-1:0]),
        .tick       (tick),
        .cur        (cur),
        .dir        (dir),
        .phase      (phase),
        .display    (display)
    );

    assign grant_cpu = cpu_req && (!seq_pend || ctrl_cpu_pri);
    assign grant_seq = seq_pend && !grant_cpu;

    // seq_pend drops at the grant edge; a tick or PATTERN write on any edge re-arms it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            seq_pend       <= 1'b0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
            cpu_ack        <= 1'b0;
        end else begin
            seq_pend <= tick || pattern_load || (seq_pend && !((state == ST_IDLE) && grant_seq));
            case (state)
                ST_IDLE: begin
                    if (cpu_req || seq_pend) begin
                        state          <= ST_WR;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        pio_writedata  <= 32'(grant_cpu ? cpu_data : display);
                        cpu_ack        <= grant_cpu;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    pio_chipselect <= 1'b0;
                    pio_write_n    <= 1'b1;
                    cpu_ack        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/leds_pattern_sequencer.md
Name: leds_pattern_sequencer

Overview:
- Controller and arbiter for the 10-bit LED output PIO.
- Drives the PIO's single-cycle Avalon write interface, and shares it between two requesters:
  - an autonomous pattern sequencer (rotate, bounce, blink at a programmable tick period);
  - a direct CPU request channel.
- Configured through its own small Avalon-MM slave, with a register map in the same style as the PIO.
- Sits between the Nios interconnect and the LED PIO in the master SoC.

Parameters:
- LED_WIDTH, 10, width of the LED pattern and PIO data.
- PRESCALE_WIDTH, 24, width of the tick period counter.
- PERIOD_RESET, 50000, reset value of the PERIOD register (clock cycles per tick).
- PATTERN_RESET, 1, reset value of the PATTERN and current-pattern registers.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low; one clock domain.
- s_address  in  2  config register select.
- s_chipselect  in  1  config slave select.
- s_write_n  in  1  config write strobe, active-low.
- s_writedata  in  32  config write data.
- s_readdata  out  32  config read data, combinational from s_address.
- cpu_req  in  1  CPU request to write cpu_data to the LEDs; level, held until cpu_ack.
- cpu_data  in  LED_WIDTH  CPU LED value.
- cpu_ack  out  1  one-cycle pulse; cpu_data written this cycle.
- pio_address  out  2  PIO address; always 0.
- pio_chipselect  out  1  PIO select.
- pio_write_n  out  1  PIO write strobe, active-low.
- pio_writedata  out  32  PIO data; zero-extended LED value.
- busy  out  1  high while a write is in progress or any request is pending.

Behaviour:
- Register map:
  - 0 CTRL: [0] en, [2:1] mode (0 manual, 1 rotate, 2 bounce, 3 blink), [3] cpu_pri.
  - 1 PERIOD: [PRESCALE_WIDTH-1:0].
  - 2 PATTERN: [LED_WIDTH-1:0].
  - 3 STATUS (read-only): [9:0] cur, [16] dir, [17] blink phase, [18] seq_pend.
  - Write takes effect when s_chipselect=1 and s_write_n=0; unused bits read 0.
- Reset (synchronous, reset_n=0 at posedge):
  - CTRL=0, PERIOD=PERIOD_RESET, PATTERN=cur=PATTERN_RESET.
  - prescaler=0, dir=left, phase=0, seq_pend=0, FSM=IDLE.
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, cpu_ack=0, busy=0.
  - An in-flight write is abandoned; chipselect is low from the first reset cycle.
- Prescaler:
  - Counts only while en=1 and mode!=0.
  - Reloads PERIOD-1 when it reaches 0 and emits a 1-cycle tick; PERIOD=0 is treated as 1, giving a tick every cycle.
  - Clearing en zeroes the prescaler; the next enable ticks after PERIOD cycles.
- On tick, cur advances and seq_pend is set:
  - rotate: cur={cur[8:0],cur[9]}.
  - bounce: shift in dir; reverse when the shifted-out end bit is set (cur[9] going left, cur[0] going right), so the pattern reflects without leaving the edge. cur=0 stays 0.
  - blink: phase toggles; displayed value = phase ? 0 : cur; cur itself is unchanged.
- A tick while seq_pend=1 still advances cur; the writes coalesce (one pending write shows the latest value).
- A PATTERN register write loads cur and sets phase=0, dir=left, seq_pend=1, in any mode including manual.
- Arbiter/FSM states IDLE, WR:
  - IDLE: if cpu_req or seq_pend, go to WR with a grant.
    - Both requesting: cpu_pri=1 grants CPU; cpu_pri=0 grants the sequencer.
  - WR (exactly 1 cycle): pio_chipselect=1, pio_write_n=0, pio_writedata={22'b0,value}.
    - CPU grant: cpu_ack=1 in this cycle.
    - Sequencer grant: seq_pend clears, unless a new tick or PATTERN write occurs in the same cycle, which sets it again.
  - WR always returns to IDLE, so there is at least 1 idle cycle between writes and the loser is served next.
- Latency:
  - seq_pend set at edge T -> PIO write cycle T+1 if granted.
  - cpu_req high in IDLE -> write and ack next cycle.
- The PIO has no waitrequest; writes are never retried.

Decomposition:
- Shared package: register address constants, CTRL bit positions, mode encodings (MODE_MANUAL/ROTATE/BOUNCE/BLINK), FSM state typedef.
- Natural sub-module: leds_pattern_gen (prescaler plus cur/dir/phase next-pattern logic); the arbiter FSM and register file stay in the top.

Test Plan:
- Reset -> pio_chipselect=0, pio_write_n=1, STATUS[9:0]=0x001, PERIOD reads 50000.
- PERIOD=4, CTRL=0x3 (en, rotate) -> PIO writes every 4 cycles: 0x002, 0x004, ... ; after 0x200 comes 0x001.
- Bounce with PATTERN=0x200, PERIOD=1 -> writes 0x100, 0x080, ... down to 0x001, then 0x002 (direction reverses at each end).
- Blink with PATTERN=0x155, PERIOD=2 -> writes alternate 0x000 and 0x155 every 2 cycles.
- cpu_req (0x3FF) and seq_pend asserted together:
  - cpu_pri=1 -> CPU write first with cpu_ack, sequencer write 2 cycles later.
  - cpu_pri=0 -> order reversed; cpu_req held until ack.
- PERIOD=1 with the arbiter blocked by a CPU request -> ticks coalesce into a single pending write carrying the latest cur.
- Reset asserted during the WR cycle -> chipselect low from the first reset cycle, no cpu_ack, registers return to their reset values.
